sr_drive_ctrl: RTL

SR_DRIVE_CTRL -- requirements
Module: sr_drive_ctrl

---
 rtl/sr_drive_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/sr_drive_ctrl.sv
// Command stage for an active-low SR latch: turns requests into timed S/R pulses with dead time.
// Optional readback checking of the latch outputs is enabled by defining SR_DRIVE_READBACK_EN.
module sr_drive_ctrl #(
  parameter int PULSE_W = 2,
  parameter int DEAD_W  = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_set,
  output logic req_ready,
  output logic s_n,
  output logic r_n,
  output logic busy,
  output logic done,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic err
);

  typedef enum logic [1:0] {IDLE, PULSE, DEAD} state_t;

  localparam logic [3:0] PULSE_LD = 4'(PULSE_W - 1);
  localparam logic [3:0] DEAD_LD  = 4'(DEAD_W - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       cmd;

  // Every output is updated together with the state, so s_n/r_n only ever move
  // between the hold level (1,1) and exactly one active-low line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd       <= 1'b0;
      s_n       <= 1'b1;
      r_n       <= 1'b1;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= PULSE;
            cnt       <= PULSE_LD;
            cmd       <= req_set;
            s_n       <= ~req_set;
            r_n       <= req_set;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            req_ready <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= DEAD;
            cnt   <= DEAD_LD;
            s_n   <= 1'b1;
            r_n   <= 1'b1;
            done  <= (DEAD_LD == '0);
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DEAD: begin
          if (cnt == '0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt  <= cnt - 4'd1;
            done <= (cnt == 4'd1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          s_n       <= 1'b1;
          r_n       <= 1'b1;
          req_ready <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SR_DRIVE_READBACK_EN
  logic [1:0] q_sync;
  logic [1:0] qb_sync;

  // Feedback is asynchronous to clk; the second flop output is compared on the done cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sync  <= '0;
      qb_sync <= '0;
      err     <= 1'b0;
    end else begin
      q_sync  <= {q_sync[0], q_fb};
      qb_sync <= {qb_sync[0], qbar_fb};
      if (done && ((q_sync[1] != cmd) || (qb_sync[1] != ~cmd)))
        err <= 1'b1;
    end
  end
`else
  logic unused_fb;
  assign unused_fb = q_fb ^ qbar_fb;
  assign err       = 1'b0;
`endif

endmodule
